subsistema_despliegue: RTL and testbench

SUBSISTEMA_DESPLIEGUE -- requirements
Module: subsistema_despliegue

---
 rtl/subsistema_despliegue_pkg.sv | 15 +
 rtl/subsistema_despliegue_value_stability_filter.sv | 53 +++++
 rtl/subsistema_despliegue.sv | 52 +++++
 tb/tb_subsistema_despliegue.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/subsistema_despliegue_pkg.sv
// Shared defaults and types for the result-to-LED display path.
package subsistema_despliegue_pkg;

    localparam int unsigned DEFAULT_WIDTH          = 16;
    localparam int unsigned DEFAULT_STABLE_CYCLES  = 0;
    localparam bit          DEFAULT_LED_ACTIVE_LOW = 1'b0;

    typedef logic [DEFAULT_WIDTH-1:0] resultado_t;

    // Counter width able to hold 0..stable_cycles; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return (stable_cycles > 1) ? $clog2(stable_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/subsistema_despliegue_value_stability_filter.sv
// Debounce filter: strobes update_c once the input has matched its previous
// sample for enough consecutive edges.
module value_stability_filter
    import subsistema_despliegue_pkg::*;
#(
    parameter int unsigned WIDTH         = DEFAULT_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] resultados,
    output logic             update_c,
    output logic [WIDTH-1:0] value_c
);

    localparam int unsigned CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W:0] THRESH = (CNT_W + 1)'(STABLE_CYCLES);

    logic [WIDTH-1:0] samp;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W:0]   cnt_plus;
    logic             match;

    // One extra bit so cnt+1 never overflows before the threshold compare.
    always_comb begin
        match    = (resultados == samp);
        cnt_plus = {1'b0, cnt} + (CNT_W + 1)'(1);
        cnt_next = '0;
        update_c = 1'b0;
        value_c  = resultados;
        if (match) begin
            cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt_plus[CNT_W-1:0];
        end
        if (STABLE_CYCLES == 0) begin
            update_c = 1'b1;
        end else begin
            update_c = match && (cnt_plus >= THRESH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp <= '0;
            cnt  <= '0;
        end else begin
            samp <= resultados;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/subsistema_despliegue.sv
// Drives the LED bank from the multiplier result through an optional
// stability filter and a selectable output polarity.
module subsistema_despliegue
    import subsistema_despliegue_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
    parameter bit          LED_ACTIVE_LOW = DEFAULT_LED_ACTIVE_LOW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] resultados,
    output logic [WIDTH-1:0] led_output
);

    logic             update_c;
    logic [WIDTH-1:0] value_c;
    logic [WIDTH-1:0] disp;
    logic [WIDTH-1:0] disp_next_c;
    logic [WIDTH-1:0] led_next_c;

    value_stability_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .resultados (resultados),
        .update_c   (update_c),
        .value_c    (value_c)
    );

    // led_output is its own flop so the pins see no logic after the register.
    always_comb begin
        disp_next_c = disp;
        if (update_c) begin
            disp_next_c = value_c;
        end
        led_next_c = LED_ACTIVE_LOW ? ~disp_next_c : disp_next_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp       <= '0;
            led_output <= LED_ACTIVE_LOW ? '1 : '0;
        end else begin
            disp       <= disp_next_c;
            led_output <= led_next_c;
        end
    end

endmodule

// File: tb/tb_subsistema_despliegue.sv
// Directed bench for subsistema_despliegue: default, filtered and
// active-low instances driven side by side.
module tb_subsistema_despliegue;

    logic        clk;
    logic        rst_def, rst_filt, rst_low;
    logic [15:0] res_def, res_filt, res_low;
    logic [15:0] led_def, led_filt, led_low;

    int checks;
    int errors;

    subsistema_despliegue dut_def (
        .clk        (clk),
        .reset      (rst_def),
        .resultados (res_def),
        .led_output (led_def)
    );

    subsistema_despliegue #(.WIDTH(16), .STABLE_CYCLES(2), .LED_ACTIVE_LOW(1'b0)) dut_filt (
        .clk        (clk),
        .reset      (rst_filt),
        .resultados (res_filt),
        .led_output (led_filt)
    );

    subsistema_despliegue #(.WIDTH(16), .STABLE_CYCLES(0), .LED_ACTIVE_LOW(1'b1)) dut_low (
        .clk        (clk),
        .reset      (rst_low),
        .resultados (res_low),
        .led_output (led_low)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_def = 1'b1; rst_filt = 1'b1; rst_low = 1'b1;
        res_def = 16'h0000; res_filt = 16'h0000; res_low = 16'h0000;
        step();
        checks++;
        if (led_def !== 16'h0000) begin
            errors++;
            $display("FAIL reset_default: got %h expected %h", led_def, 16'h0000);
        end
        checks++;
        if (led_filt !== 16'h0000) begin
            errors++;
            $display("FAIL reset_filtered: got %h expected %h", led_filt, 16'h0000);
        end
        checks++;
        if (led_low !== 16'hFFFF) begin
            errors++;
            $display("FAIL reset_active_low: got %h expected %h", led_low, 16'hFFFF);
        end
        rst_def = 1'b0; rst_filt = 1'b0; rst_low = 1'b0;
    endtask

    task automatic test_passthrough();
        res_def = 16'hAAAA;
        step();
        checks++;
        if (led_def !== 16'hAAAA) begin
            errors++;
            $display("FAIL pass_aaaa: got %h expected %h", led_def, 16'hAAAA);
        end
        res_def = 16'h5555;
        step();
        checks++;
        if (led_def !== 16'h5555) begin
            errors++;
            $display("FAIL pass_5555: got %h expected %h", led_def, 16'h5555);
        end
    endtask

    task automatic test_active_low();
        res_low = 16'h00F0;
        step();
        checks++;
        if (led_low !== 16'hFF0F) begin
            errors++;
            $display("FAIL active_low_00f0: got %h expected %h", led_low, 16'hFF0F);
        end
    endtask

    task automatic test_filter();
        logic [15:0] exp_seq [3];
        exp_seq[0] = 16'h0000;
        exp_seq[1] = 16'h0000;
        exp_seq[2] = 16'h1234;
        res_filt = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (led_filt !== exp_seq[i]) begin
                errors++;
                $display("FAIL filter_settle_edge%0d: got %h expected %h", i + 1, led_filt, exp_seq[i]);
            end
        end
        // Hold long enough for the counter to saturate; display must not move.
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (led_filt !== 16'h1234) begin
                errors++;
                $display("FAIL filter_hold_%0d: got %h expected %h", i, led_filt, 16'h1234);
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] glitch [3];
        glitch[0] = 16'hFFFF;
        glitch[1] = 16'h1235;
        glitch[2] = 16'h9234;
        for (int g = 0; g < 3; g++) begin
            res_filt = glitch[g];
            for (int i = 0; i < 2; i++) begin
                step();
                checks++;
                if (led_filt !== 16'h1234) begin
                    errors++;
                    $display("FAIL glitch_%h_edge%0d: got %h expected %h", glitch[g], i, led_filt, 16'h1234);
                end
            end
            res_filt = 16'h1234;
            for (int i = 0; i < 3; i++) begin
                step();
                checks++;
                if (led_filt !== 16'h1234) begin
                    errors++;
                    $display("FAIL glitch_recover_%h_%0d: got %h expected %h", glitch[g], i, led_filt, 16'h1234);
                end
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        res_filt = 16'h8001;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (led_filt !== 16'h1234) begin
                errors++;
                $display("FAIL midreset_pending_%0d: got %h expected %h", i, led_filt, 16'h1234);
            end
        end
        rst_filt = 1'b1;
        step();
        checks++;
        if (led_filt !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_cleared: got %h expected %h", led_filt, 16'h0000);
        end
        rst_filt = 1'b0;
        step();
        checks++;
        if (led_filt !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_restart_edge1: got %h expected %h", led_filt, 16'h0000);
        end
        step();
        step();
        checks++;
        if (led_filt !== 16'h8001) begin
            errors++;
            $display("FAIL midreset_restart_shown: got %h expected %h", led_filt, 16'h8001);
        end
    endtask

    task automatic test_toggle();
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v = (i % 2 == 0) ? 16'h0001 : 16'h8000;
            res_def = v;
            step();
            checks++;
            if (led_def !== v) begin
                errors++;
                $display("FAIL toggle_%0d: got %h expected %h", i, led_def, v);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_def = 1'b1; rst_filt = 1'b1; rst_low = 1'b1;
        res_def = '0; res_filt = '0; res_low = '0;
        test_reset();
        test_passthrough();
        test_active_low();
        test_filter();
        test_glitch();
        test_reset_mid_filter();
        test_toggle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
